// File: rtl/gshare_ongorucu_param.sv
// Parametrised gshare direction predictor: PC ^ global history indexes a table of saturating counters.
// Define GSHARE_SPEC_GHR_EN for speculative global history with mispredict repair.
module gshare_ongorucu_param #(
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int PC_LSB      = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tahmin_ps_gecerli_i,
  input  logic [31:0]         tahmin_ps_i,
  input  logic [31:0]         ongoru_genisletilmis_anlik_i,
  output logic                ongorulen_ps_gecerli_o,
  output logic [31:0]         ongorulen_ps_o,
  output logic                ongorulen_atla_o,
  output logic [GHR_BITS-1:0] ongorulen_gecmis_o,
  input  logic                yurut_ps_gecerli_i,
  input  logic [31:0]         yurut_ps_i,
  input  logic [GHR_BITS-1:0] yurut_gecmis_i,
  input  logic                yurut_atladi_i,
  input  logic                yanlis_tahmin_i
);

  localparam int IDX_BITS = $clog2(PHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0] pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr, ghr_nxt;

  function automatic logic [IDX_BITS-1:0] idx_of(input logic [31:0] pc,
                                                 input logic [GHR_BITS-1:0] h);
    return pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(h);
  endfunction

  // Written as a loop so a one-bit history needs no special case.
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                   input logic b);
    logic [GHR_BITS-1:0] r;
    r[0] = b;
    for (int i = 1; i < GHR_BITS; i++) r[i] = h[i-1];
    return r;
  endfunction

  logic [IDX_BITS-1:0] pred_idx, upd_idx;
  logic                pred_taken;
  logic [CTR_BITS-1:0] upd_ctr, upd_ctr_nxt;

  assign pred_idx   = idx_of(tahmin_ps_i, ghr);
  assign pred_taken = pht[pred_idx][CTR_BITS-1];
  assign upd_idx    = idx_of(yurut_ps_i, yurut_gecmis_i);
  assign upd_ctr    = pht[upd_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    upd_ctr_nxt = upd_ctr;
    if (yurut_atladi_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - CTR_BITS'(1);
    end
  end

`ifdef GSHARE_SPEC_GHR_EN
  // Repair is applied last so it overrides the speculative shift of a same-cycle prediction.
  always_comb begin
    ghr_nxt = ghr;
    if (tahmin_ps_gecerli_i) ghr_nxt = shift_in(ghr, pred_taken);
    if (yurut_ps_gecerli_i && yanlis_tahmin_i) ghr_nxt = shift_in(yurut_gecmis_i, yurut_atladi_i);
  end
`else
  always_comb begin
    ghr_nxt = ghr;
    if (yurut_ps_gecerli_i) ghr_nxt = shift_in(ghr, yurut_atladi_i);
  end
`endif

  // Only the index slice of the update PC matters; the mispredict flag is unused without speculation.
  logic unused_sigs;
  assign unused_sigs = ^{yurut_ps_i, yanlis_tahmin_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ongorulen_ps_gecerli_o <= 1'b0;
      ongorulen_ps_o         <= '0;
      ongorulen_atla_o       <= 1'b0;
      ongorulen_gecmis_o     <= '0;
      ghr                    <= '0;
      // NOTE: the counter table lives in flops, not RAM, because every entry must return to weak not-taken on reset.
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
    end else begin
      // NOTE: non-blocking assignments keep the prediction read of pht/ghr on pre-edge values.
      ongorulen_ps_gecerli_o <= tahmin_ps_gecerli_i;
      if (tahmin_ps_gecerli_i) begin
        ongorulen_atla_o   <= pred_taken;
        ongorulen_ps_o     <= tahmin_ps_i + (pred_taken ? ongoru_genisletilmis_anlik_i : 32'd4);
        ongorulen_gecmis_o <= ghr;
      end
      if (yurut_ps_gecerli_i) pht[upd_idx] <= upd_ctr_nxt;
      ghr <= ghr_nxt;
    end
  end

endmodule

// File: tb/tb_gshare_ongorucu_param.sv
// Scoreboard bench for gshare_ongorucu_param (default parameters); stimulus pushes expectations, a monitor pops them.
module tb_gshare_ongorucu_param;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tahmin_ps_gecerli_i = 1'b0;
  logic [31:0] tahmin_ps_i = '0;
  logic [31:0] ongoru_genisletilmis_anlik_i = '0;
  logic        ongorulen_ps_gecerli_o;
  logic [31:0] ongorulen_ps_o;
  logic        ongorulen_atla_o;
  logic [7:0]  ongorulen_gecmis_o;
  logic        yurut_ps_gecerli_i = 1'b0;
  logic [31:0] yurut_ps_i = '0;
  logic [7:0]  yurut_gecmis_i = '0;
  logic        yurut_atladi_i = 1'b0;
  logic        yanlis_tahmin_i = 1'b0;

  gshare_ongorucu_param dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .tahmin_ps_gecerli_i          (tahmin_ps_gecerli_i),
    .tahmin_ps_i                  (tahmin_ps_i),
    .ongoru_genisletilmis_anlik_i (ongoru_genisletilmis_anlik_i),
    .ongorulen_ps_gecerli_o       (ongorulen_ps_gecerli_o),
    .ongorulen_ps_o               (ongorulen_ps_o),
    .ongorulen_atla_o             (ongorulen_atla_o),
    .ongorulen_gecmis_o           (ongorulen_gecmis_o),
    .yurut_ps_gecerli_i           (yurut_ps_gecerli_i),
    .yurut_ps_i                   (yurut_ps_i),
    .yurut_gecmis_i               (yurut_gecmis_i),
    .yurut_atladi_i               (yurut_atladi_i),
    .yanlis_tahmin_i              (yanlis_tahmin_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        atla;
    logic [31:0] ps;
    logic [7:0]  gecmis;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every valid prediction must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni && ongorulen_ps_gecerli_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pred_atla",   {31'd0, ongorulen_atla_o}, {31'd0, e.atla});
        check("pred_ps",     ongorulen_ps_o, e.ps);
        check("pred_gecmis", {24'd0, ongorulen_gecmis_o}, {24'd0, e.gecmis});
      end
    end
  end

  function automatic exp_t mk(input logic a, input logic [31:0] p, input logic [7:0] g);
    exp_t e;
    e.atla = a; e.ps = p; e.gecmis = g;
    return e;
  endfunction

  task automatic predict(input logic [31:0] pc, input logic [31:0] imm,
                         input logic ea, input logic [31:0] eps, input logic [7:0] eg);
    tahmin_ps_gecerli_i = 1'b1; tahmin_ps_i = pc; ongoru_genisletilmis_anlik_i = imm;
    sb_q.push_back(mk(ea, eps, eg));
    @(posedge clk_i); #1;
    tahmin_ps_gecerli_i = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic mis);
    yurut_ps_gecerli_i = 1'b1; yurut_ps_i = pc; yurut_gecmis_i = g;
    yurut_atladi_i = t; yanlis_tahmin_i = mis;
    @(posedge clk_i); #1;
    yurut_ps_gecerli_i = 1'b0; yanlis_tahmin_i = 1'b0;
  endtask

  task automatic both(input logic [31:0] pc, input logic [31:0] imm,
                      input logic ea, input logic [31:0] eps, input logic [7:0] eg,
                      input logic [31:0] upc, input logic [7:0] ug, input logic t, input logic mis);
    yurut_ps_gecerli_i = 1'b1; yurut_ps_i = upc; yurut_gecmis_i = ug;
    yurut_atladi_i = t; yanlis_tahmin_i = mis;
    predict(pc, imm, ea, eps, eg);
    yurut_ps_gecerli_i = 1'b0; yanlis_tahmin_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},  {31'd0, ongorulen_ps_gecerli_o}, 32'd0);
    check({tag, "_ps"},     ongorulen_ps_o, 32'd0);
    check({tag, "_atla"},   {31'd0, ongorulen_atla_o}, 32'd0);
    check({tag, "_gecmis"}, {24'd0, ongorulen_gecmis_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 check_outputs_zero("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

`ifndef GSHARE_SPEC_GHR_EN
    // Fresh state: weak not-taken, history zero.
    predict(32'h100, 32'h40, 1'b0, 32'h104, 8'h00);
    // Three taken trainings of PHT[0x80]; mispredict flag must not matter. GHR -> 0x07.
    update(32'h100, 8'h00, 1'b1, 1'b1);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    predict(32'h100, 32'h40, 1'b0, 32'h104, 8'h07);   // idx 0x87, untouched
    predict(32'h10E, 32'h40, 1'b1, 32'h14E, 8'h07);   // idx 0x80, saturated taken
    // Same-cycle predict and taken update on idx 0x07: old counter seen. GHR -> 0x0F.
    both(32'h200, 32'h10, 1'b0, 32'h204, 8'h07, 32'h200, 8'h07, 1'b1, 1'b0);
    predict(32'h10, 32'h10, 1'b1, 32'h20, 8'h0F);     // idx 0x08^0x0F = 0x07, now 2
    @(negedge clk_i); @(negedge clk_i);
    check("idle_valid", {31'd0, ongorulen_ps_gecerli_o}, 32'd0);
    check("idle_ps_hold", ongorulen_ps_o, 32'h20);
    check("idle_atla_hold", {31'd0, ongorulen_atla_o}, 32'd1);
    @(posedge clk_i); #1;
    // Wrap: train idx 0xE7 (GHR -> 0x1F), then taken and not-taken wraps.
    update(32'hFFFF_FFF0, 8'h1F, 1'b1, 1'b0);
    predict(32'hFFFF_FFF0, 32'h20, 1'b1, 32'h0000_0010, 8'h1F);
    predict(32'hFFFF_FFFC, 32'h20, 1'b0, 32'h0000_0000, 8'h1F);
    // Saturation at 0: two decrements then one increment leaves idx 0 not-taken. GHR 0x1F->0x3E->0x7C->0xF9.
    update(32'h0, 8'h00, 1'b0, 1'b0);
    update(32'h0, 8'h00, 1'b0, 1'b0);
    update(32'h0, 8'h00, 1'b1, 1'b0);
    predict(32'h1F2, 32'h40, 1'b0, 32'h1F6, 8'hF9);
`else
    // Repair GHR to {0x02[6:0],1} = 0x05 and train PHT[0x02] to 2.
    update(32'h0, 8'h02, 1'b1, 1'b1);
    // Taken prediction on idx 0x07^0x05 = 0x02 with a simultaneous repair: repair wins -> 0x0A.
    both(32'h0E, 32'h10, 1'b1, 32'h1E, 8'h05, 32'h40, 8'h05, 1'b0, 1'b1);
    predict(32'h0, 32'h0, 1'b0, 32'h4, 8'h0A);        // speculative shift -> 0x14
    predict(32'h0, 32'h0, 1'b0, 32'h4, 8'h14);        // -> 0x28
    update(32'h0, 8'h00, 1'b1, 1'b0);                 // no mispredict: GHR stays 0x28
    predict(32'h0, 32'h0, 1'b0, 32'h4, 8'h28);
`endif

    // Asynchronous reset between edges while a prediction is being presented.
    tahmin_ps_gecerli_i = 1'b1; tahmin_ps_i = 32'h300; ongoru_genisletilmis_anlik_i = 32'h8;
    @(posedge clk_i); #2;
    tahmin_ps_gecerli_i = 1'b0;
    rst_ni = 1'b0;
    #1 check_outputs_zero("midreset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    predict(32'h100, 32'h40, 1'b0, 32'h104, 8'h00);   // PHT[0x80] back to weak not-taken
    predict(32'h10E, 32'h40, 1'b0, 32'h112, 8'h00);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
